matmul_host_sequencer: RTL and testbench
========================================

# matmul_host_sequencer

Host-side initiator for the 32x32 fp16 matrix-multiplication top: it drives that top's memory-load/unload port. It accepts 64 rows over a valid/ready input stream (32 rows of A, then 32 rows of B) and writes them into the A/B BRAMs. It then runs the multiply and streams the 32 result rows of C out over a valid/ready output stream with backpressure. It sits between the system DMA/testbench and the matmul top, in the clk_mem domain; the matmul `clk` is tied to the same clock.

## Interface
Parameters:
- DWIDTH, 16, fp16 element width
- ROW_ELEMS, 32, elements per row (row width W = ROW_ELEMS*DWIDTH = 512)
- AWIDTH, 7, BRAM address width
- NUM_ROWS, 32, rows per matrix
- WR_ADDR_LAT, 2, cycles from addr_pi to RAM address in the top
- RD_LAT, 4, cycles from addr_pi to data_from_out_mat

Ports:
- clk_mem  in  1  clock
- reset  in  1  synchronous, active-high
- go  in  1  single-cycle start request, honoured only in IDLE
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse when the last C row is accepted
- in_valid / in_ready / in_data  in / out / W  input row stream
- out_valid / out_ready / out_data / out_last  out / in / W / out  C row stream; out_last marks row 31
- enable_writing_to_mem, enable_reading_from_mem  out  1  top mode controls
- addr_pi  out  AWIDTH  row address to top
- data_pi  out  W  write data to top
- we_a, we_b, we_c  out  1  BRAM write enables
- start_mat_mul  out  1  compute request
- done_mat_mul  in  1  compute complete
- data_from_out_mat  in  W  C read data
- compute_cycles  out  16  performance count (see Configuration)

## Operation
- States: IDLE -> LOAD_A -> LOAD_B -> DRAIN_WR -> COMPUTE -> UNLOAD -> FLUSH -> IDLE.
- IDLE: all outputs 0, in_ready 0. go=1 moves to LOAD_A, sets enable_writing_to_mem=1 and clears the row counter.
- LOAD_A / LOAD_B: in_ready=1. Each handshake sets addr_pi=row. data_pi=in_data and we_a (or we_b) follow exactly WR_ADDR_LAT cycles later, one cycle wide, via a 2-deep delay line. Row 31 accepted -> counter wraps to 0 and advances the state.
- DRAIN_WR: 3 cycles. enable_writing_to_mem stays high until the final write lands, then drops to 0.
- COMPUTE: start_mat_mul=1 and we_c=1, held until done_mat_mul is sampled high. Both drop the cycle after; the state then moves to UNLOAD.
- UNLOAD: enable_reading_from_mem=1. Read address k is issued when credits > 0, where credits = 4 − FIFO occupancy − reads in flight. The return data_from_out_mat is captured RD_LAT cycles after issue into a 4-deep FIFO. The FIFO drives out_*. After address 31 is issued, move to FLUSH.
- FLUSH: the state waits until the FIFO is empty and row 31 has been accepted, then pulses done, deasserts enable_reading_from_mem and returns to IDLE.
- Input handshakes outside LOAD_*: ignored (in_ready=0). go while busy: ignored.
- reset at any time: state=IDLE, all outputs 0, FIFO and delay lines cleared, in-flight reads discarded.

## Timing
- addr_pi, data_pi, enables and start are registered outputs. in_ready and out_valid are registered/FIFO-derived.
- Write alignment: handshake at edge E -> addr_pi valid after E, data_pi/we_x valid after E+2.
- First possible input handshake: edge G+1, where G is the go edge.
- Read latency: address issued after edge E -> data sampled at edge E+RD_LAT.
- Input throughput: 1 row/cycle. Output throughput: 1 row/cycle with out_ready held high.
- With out_ready low, no more than 4 reads are outstanding, so the FIFO never overflows and no row is lost.

## Configuration
- SEQ_PERF_COUNTER_EN defined: compute_cycles counts clk_mem cycles with start_mat_mul high. It clears on go, saturates at 0xFFFF, and holds its value until the next go.
- SEQ_PERF_COUNTER_EN not defined: compute_cycles is constant 0 and no counter logic is built.

## Structure
- Shared package: state enum, the constants NUM_ROWS/RD_LAT/WR_ADDR_LAT, and the FIFO depth (4).
- One sub-module: matmul_rd_fifo, a synchronous 4-entry W-bit FIFO carrying out_last alongside the data, with a count output.

## Test plan
- Full run, always-ready sink, A=identity, B rows filled with 0x3C00 (1.0): 64 inputs accepted; we_a/we_b pulse 32 times each at addr 0..31 +2 cycles; 32 output rows all 0x3C00; out_last on row 31; done pulses once.
- Input gaps (in_valid low every other cycle): write address/data alignment holds; BRAM contents match.
- Sink backpressure (out_ready random 30%): output order 0..31 preserved; never more than 4 reads outstanding; no row dropped or duplicated.
- done_mat_mul held low for 1000 cycles: start_mat_mul and we_c stay high throughout; with SEQ_PERF_COUNTER_EN, compute_cycles ≥ 1000 after completion.
- reset asserted mid-UNLOAD at row 10: the next cycle shows busy=0 and every output 0; a following go runs a clean full sequence.
- go pulsed during LOAD_B: ignored; the sequence completes unchanged.

Source files
------------

// File: rtl/matmul_host_sequencer_pkg.sv
// Shared types and constants for the matmul host sequencer and its read-return FIFO.
package matmul_host_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_A,
    ST_LOAD_B,
    ST_DRAIN_WR,
    ST_COMPUTE,
    ST_UNLOAD,
    ST_FLUSH
  } seq_state_e;

  localparam int SEQ_NUM_ROWS    = 32;
  localparam int SEQ_RD_LAT      = 4;
  localparam int SEQ_WR_ADDR_LAT = 2;
  localparam int SEQ_FIFO_DEPTH  = 4;
  localparam int SEQ_FIFO_CNT_W  = $clog2(SEQ_FIFO_DEPTH + 1);

endpackage

// File: rtl/matmul_rd_fifo.sv
// Synchronous read-return FIFO for C rows; each entry carries its last-row flag.
module matmul_rd_fifo
  import matmul_host_sequencer_pkg::*;
#(
  parameter int W      = 512,
  parameter int DEPTH  = SEQ_FIFO_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [W-1:0]     push_data_i,
  input  logic             push_last_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [W-1:0]     data_o,
  output logic             last_o,
  output logic [CNT_W-1:0] count_o
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [DEPTH-1:0] last_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
    end else begin
      if (push_i) begin
        last_q[wr_ptr_q] <= push_last_i;
        wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_i) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Stale entries are masked so an empty FIFO presents all-zero outputs.
  assign valid_o = (count_q != '0);
  assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;
  assign last_o  = valid_o & last_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/matmul_host_sequencer.sv
// Host-side sequencer: loads A/B rows, runs the multiply, streams C rows out.
// Optional SEQ_PERF_COUNTER_EN builds a saturating compute-cycle counter.
module matmul_host_sequencer
  import matmul_host_sequencer_pkg::*;
#(
  parameter int DWIDTH      = 16,
  parameter int ROW_ELEMS   = 32,
  parameter int AWIDTH      = 7,
  parameter int NUM_ROWS    = SEQ_NUM_ROWS,
  parameter int WR_ADDR_LAT = SEQ_WR_ADDR_LAT,
  parameter int RD_LAT      = SEQ_RD_LAT,
  localparam int W          = ROW_ELEMS * DWIDTH
) (
  input  logic              clk_mem,
  input  logic              reset,
  input  logic              go,
  output logic              busy,
  output logic              done,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W-1:0]      in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      out_data,
  output logic              out_last,
  output logic              enable_writing_to_mem,
  output logic              enable_reading_from_mem,
  output logic [AWIDTH-1:0] addr_pi,
  output logic [W-1:0]      data_pi,
  output logic              we_a,
  output logic              we_b,
  output logic              we_c,
  output logic              start_mat_mul,
  input  logic              done_mat_mul,
  input  logic [W-1:0]      data_from_out_mat,
  output logic [15:0]       compute_cycles
);

  seq_state_e                     state_q;
  logic [AWIDTH-1:0]              row_q, addr_q;
  logic [3:0]                     drain_q;
  logic                           in_ready_q, en_wr_q, en_rd_q, start_q, we_c_q, done_q;
  logic [WR_ADDR_LAT-1:0]         wr_vld_q, wr_b_q;
  logic [WR_ADDR_LAT-1:0][W-1:0]  wr_data_q;
  logic [W-1:0]                   data_pi_q;
  logic                           we_a_q, we_b_q;
  logic [RD_LAT-1:0]              rd_vld_q, rd_last_q;
  logic [SEQ_FIFO_CNT_W-1:0]      fifo_cnt;
  logic                           fifo_valid, fifo_last, pop;
  logic [3:0]                     inflight_d, outst_d;
  logic                           in_hs, row_last, issue;

  assign in_hs    = in_valid & in_ready_q;
  assign row_last = (row_q == AWIDTH'(NUM_ROWS - 1));
  assign pop      = fifo_valid & out_ready;

  // A slot freed by this cycle's pop may be re-issued immediately.
  always_comb begin
    inflight_d = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight_d = inflight_d + {3'b000, rd_vld_q[i]};
    end
    outst_d = 4'(fifo_cnt) + inflight_d - {3'b000, pop};
  end
  assign issue = (state_q == ST_UNLOAD) && (outst_d < 4'(SEQ_FIFO_DEPTH));

  always_ff @(posedge clk_mem) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      row_q      <= '0;
      addr_q     <= '0;
      drain_q    <= '0;
      in_ready_q <= 1'b0;
      en_wr_q    <= 1'b0;
      en_rd_q    <= 1'b0;
      start_q    <= 1'b0;
      we_c_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (go) begin
            state_q    <= ST_LOAD_A;
            en_wr_q    <= 1'b1;
            in_ready_q <= 1'b1;
            row_q      <= '0;
          end
        end
        ST_LOAD_A, ST_LOAD_B: begin
          if (in_hs) begin
            addr_q <= row_q;
            if (row_last) begin
              row_q <= '0;
              if (state_q == ST_LOAD_A) begin
                state_q <= ST_LOAD_B;
              end else begin
                state_q    <= ST_DRAIN_WR;
                in_ready_q <= 1'b0;
                drain_q    <= '0;
              end
            end else begin
              row_q <= row_q + AWIDTH'(1);
            end
          end
        end
        // Hold write mode until the last delayed B write has reached the RAM.
        ST_DRAIN_WR: begin
          if (drain_q == 4'(WR_ADDR_LAT)) begin
            state_q <= ST_COMPUTE;
            en_wr_q <= 1'b0;
            start_q <= 1'b1;
            we_c_q  <= 1'b1;
          end else begin
            drain_q <= drain_q + 4'd1;
          end
        end
        ST_COMPUTE: begin
          if (done_mat_mul) begin
            state_q <= ST_UNLOAD;
            start_q <= 1'b0;
            we_c_q  <= 1'b0;
            en_rd_q <= 1'b1;
            row_q   <= '0;
          end
        end
        ST_UNLOAD: begin
          if (issue) begin
            addr_q <= row_q;
            if (row_last) begin
              state_q <= ST_FLUSH;
            end else begin
              row_q <= row_q + AWIDTH'(1);
            end
          end
        end
        ST_FLUSH: begin
          if (pop && fifo_last) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
            en_rd_q <= 1'b0;
            addr_q  <= '0;
            row_q   <= '0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Write data/enable trail the address by WR_ADDR_LAT cycles.
  always_ff @(posedge clk_mem) begin
    if (reset) begin
      wr_vld_q  <= '0;
      wr_b_q    <= '0;
      wr_data_q <= '0;
      data_pi_q <= '0;
      we_a_q    <= 1'b0;
      we_b_q    <= 1'b0;
    end else begin
      wr_vld_q[0]  <= in_hs;
      wr_b_q[0]    <= (state_q == ST_LOAD_B);
      wr_data_q[0] <= in_hs ? in_data : '0;
      for (int i = 1; i < WR_ADDR_LAT; i++) begin
        wr_vld_q[i]  <= wr_vld_q[i-1];
        wr_b_q[i]    <= wr_b_q[i-1];
        wr_data_q[i] <= wr_data_q[i-1];
      end
      we_a_q    <= wr_vld_q[WR_ADDR_LAT-1] & ~wr_b_q[WR_ADDR_LAT-1];
      we_b_q    <= wr_vld_q[WR_ADDR_LAT-1] &  wr_b_q[WR_ADDR_LAT-1];
      data_pi_q <= wr_vld_q[WR_ADDR_LAT-1] ? wr_data_q[WR_ADDR_LAT-1] : '0;
    end
  end

  always_ff @(posedge clk_mem) begin
    if (reset) begin
      rd_vld_q  <= '0;
      rd_last_q <= '0;
    end else begin
      rd_vld_q[0]  <= issue;
      rd_last_q[0] <= issue & row_last;
      for (int i = 1; i < RD_LAT; i++) begin
        rd_vld_q[i]  <= rd_vld_q[i-1];
        rd_last_q[i] <= rd_last_q[i-1];
      end
    end
  end

  matmul_rd_fifo #(
    .W     (W),
    .DEPTH (SEQ_FIFO_DEPTH)
  ) u_rd_fifo (
    .clk_i       (clk_mem),
    .rst_i       (reset),
    .push_i      (rd_vld_q[RD_LAT-1]),
    .push_data_i (data_from_out_mat),
    .push_last_i (rd_last_q[RD_LAT-1]),
    .pop_i       (pop),
    .valid_o     (fifo_valid),
    .data_o      (out_data),
    .last_o      (fifo_last),
    .count_o     (fifo_cnt)
  );

`ifdef SEQ_PERF_COUNTER_EN
  logic [15:0] perf_q;

  always_ff @(posedge clk_mem) begin
    if (reset) begin
      perf_q <= '0;
    end else if ((state_q == ST_IDLE) && go) begin
      perf_q <= '0;
    end else if (start_q && (perf_q != 16'hFFFF)) begin
      perf_q <= perf_q + 16'd1;
    end
  end

  assign compute_cycles = perf_q;
`else
  assign compute_cycles = '0;
`endif

  assign busy                    = (state_q != ST_IDLE);
  assign done                    = done_q;
  assign in_ready                = in_ready_q;
  assign out_valid               = fifo_valid;
  assign out_last                = fifo_last;
  assign enable_writing_to_mem   = en_wr_q;
  assign enable_reading_from_mem = en_rd_q;
  assign addr_pi                 = addr_q;
  assign data_pi                 = data_pi_q;
  assign we_a                    = we_a_q;
  assign we_b                    = we_b_q;
  assign we_c                    = we_c_q;
  assign start_mat_mul           = start_q;

endmodule

// File: tb/tb_matmul_host_sequencer.sv
// Bench for matmul_host_sequencer: a permutation-matrix matmul top stub plus a scoreboard
// that predicts written rows and C = A*B output rows from the input stream.
module tb_matmul_host_sequencer;

  localparam int W  = 512;
  localparam int NR = 32;

  logic           clk_mem = 1'b0;
  logic           reset = 1'b1;
  logic           go = 1'b0;
  logic           in_valid = 1'b0;
  logic           out_ready = 1'b0;
  logic           done_mat_mul = 1'b0;
  logic [W-1:0]   in_data = '0;
  logic [W-1:0]   data_from_out_mat = '0;
  logic           in_ready, busy, done, out_valid, out_last;
  logic           enable_writing_to_mem, enable_reading_from_mem;
  logic           we_a, we_b, we_c, start_mat_mul;
  logic [W-1:0]   out_data, data_pi;
  logic [6:0]     addr_pi;
  logic [15:0]    compute_cycles;

  matmul_host_sequencer dut (
    .clk_mem                 (clk_mem),
    .reset                   (reset),
    .go                      (go),
    .busy                    (busy),
    .done                    (done),
    .in_valid                (in_valid),
    .in_ready                (in_ready),
    .in_data                 (in_data),
    .out_valid               (out_valid),
    .out_ready               (out_ready),
    .out_data                (out_data),
    .out_last                (out_last),
    .enable_writing_to_mem   (enable_writing_to_mem),
    .enable_reading_from_mem (enable_reading_from_mem),
    .addr_pi                 (addr_pi),
    .data_pi                 (data_pi),
    .we_a                    (we_a),
    .we_b                    (we_b),
    .we_c                    (we_c),
    .start_mat_mul           (start_mat_mul),
    .done_mat_mul            (done_mat_mul),
    .data_from_out_mat       (data_from_out_mat),
    .compute_cycles          (compute_cycles)
  );

  always #5 clk_mem = ~clk_mem;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected matrices: A is a permutation matrix, so C row r equals B row perm[r].
  logic [W-1:0] a_exp [NR];
  logic [W-1:0] b_exp [NR];
  int           perm  [NR];
  logic [W-1:0] a_mem [128];
  logic [W-1:0] b_mem [128];
  logic [W-1:0] c_mem [128];
  logic [6:0]   ah    [4];
  logic [6:0]   prev_addr = '0;

  // Run controls, written only by the main sequence.
  int  run_id = 0;
  bit  gap_mode = 0, src_en = 0, sink_en = 0, run_active = 0;
  int  ready_pct = 100;
  int  compute_lat = 1;

  // Scoreboard counters, written only by the environment process.
  int  seen_id = 0;
  int  in_sent, we_a_cnt, we_b_cnt, out_cnt, issued, max_out, done_cnt, start_cyc, wec_bad;
  bit  last_pending, gap_tgl;

  always @(negedge clk_mem) begin
    if (run_id != seen_id) begin
      seen_id = run_id;
      in_sent = 0; we_a_cnt = 0; we_b_cnt = 0; out_cnt = 0; issued = 0; max_out = 0;
      done_cnt = 0; start_cyc = 0; wec_bad = 0; last_pending = 0; gap_tgl = 0;
    end
    for (int i = 3; i > 0; i--) ah[i] = ah[i-1];
    ah[0] = addr_pi;
    data_from_out_mat = c_mem[ah[3]];

    // Matmul top stub: hold start for compute_lat cycles, then compute C and signal done.
    if (start_mat_mul) begin
      start_cyc++;
      if (we_c !== 1'b1) wec_bad++;
      if (start_cyc >= compute_lat && !done_mat_mul) begin
        for (int r = 0; r < NR; r++) begin
          c_mem[r] = '0;
          for (int j = 0; j < NR; j++)
            if (a_mem[r][j*16 +: 16] == 16'h3C00) c_mem[r] = b_mem[j];
        end
        done_mat_mul = 1'b1;
      end
    end else begin
      done_mat_mul = 1'b0;
    end

    if (run_active) begin
      if (last_pending) begin
        check_val("done_after_last", done, 1'b1);
        check_val("idle_after_last", busy, 1'b0);
        last_pending = 0;
      end
      if (done) done_cnt++;
      if (we_a) begin
        if (we_a_cnt < NR) begin
          check_val("wr_a_addr", ah[2], we_a_cnt);
          check_val("wr_a_data", data_pi, a_exp[we_a_cnt]);
        end
        a_mem[ah[2]] = data_pi;
        we_a_cnt++;
      end
      if (we_b) begin
        if (we_b_cnt < NR) begin
          check_val("wr_b_addr", ah[2], we_b_cnt);
          check_val("wr_b_data", data_pi, b_exp[we_b_cnt]);
        end
        b_mem[ah[2]] = data_pi;
        we_b_cnt++;
      end
      if (enable_reading_from_mem && addr_pi != prev_addr) issued++;
      if (issued - out_cnt > max_out) max_out = issued - out_cnt;
    end
    prev_addr = addr_pi;

    out_ready = ($urandom_range(99, 0) < ready_pct);
    if (sink_en && out_valid && out_ready) begin
      if (out_cnt < NR) begin
        check_val("out_data", out_data, b_exp[perm[out_cnt]]);
        check_val("out_last", out_last, (out_cnt == NR - 1));
      end
      if (out_cnt == NR - 1) last_pending = 1;
      out_cnt++;
    end

    if (src_en) begin
      if (in_sent < 2 * NR) begin
        in_valid = gap_mode ? gap_tgl : 1'b1;
        gap_tgl  = ~gap_tgl;
      end else begin
        in_valid = 1'b1;
      end
      if (in_valid && in_sent < NR)          in_data = a_exp[in_sent];
      else if (in_valid && in_sent < 2 * NR) in_data = b_exp[in_sent - NR];
      else                                   in_data = {16{$urandom}};
      if (in_valid && in_ready) in_sent++;
    end else begin
      in_valid = 1'b0;
    end
  end

  task automatic check_all_zero(input string tag);
    check_val({tag, "_ctrl"}, {busy, done, in_ready, out_valid, out_last, enable_writing_to_mem,
                               enable_reading_from_mem, we_a, we_b, we_c, start_mat_mul,
                               addr_pi, compute_cycles}, '0);
    check_val({tag, "_data"}, data_pi | out_data, '0);
  endtask

  task automatic run_seq(input bit ident, input bit gaps, input int pct, input int lat,
                         input bit go_mid, input int rst_row);
    int c;
    int j;
    int tmp;
    logic [15:0] exp_cc;
    @(posedge clk_mem);
    for (int i = 0; i < NR; i++) perm[i] = i;
    if (!ident) begin
      for (int i = NR - 1; i > 0; i--) begin
        j = $urandom_range(i, 0);
        tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
      end
    end
    for (int r = 0; r < NR; r++) begin
      a_exp[r] = '0;
      a_exp[r][perm[r]*16 +: 16] = 16'h3C00;
      for (int e = 0; e < NR; e++) b_exp[r][e*16 +: 16] = ident ? 16'h3C00 : 16'($urandom);
    end
    gap_mode = gaps; ready_pct = pct; compute_lat = lat;
    src_en = 1; sink_en = 1; run_active = 1;
    run_id++;
    @(negedge clk_mem);
    @(negedge clk_mem); go = 1'b1;
    @(negedge clk_mem); go = 1'b0;
    check_val("in_ready_after_go", in_ready, 1'b1);
    check_val("busy_after_go", busy, 1'b1);
    if (go_mid) begin
      c = 0;
      while (in_sent < 40 && c < 500) begin @(posedge clk_mem); c++; end
      check_val("reached_load_b", (in_sent >= 40), 1'b1);
      @(negedge clk_mem); go = 1'b1;
      @(negedge clk_mem); go = 1'b0;
    end
    if (rst_row >= 0) begin
      c = 0;
      while (out_cnt < rst_row && c < 5000) begin @(posedge clk_mem); c++; end
      check_val("reached_reset_row", (out_cnt >= rst_row), 1'b1);
      sink_en = 0; run_active = 0;
      @(negedge clk_mem); reset = 1'b1;
      @(negedge clk_mem);
      check_all_zero("mid_unload_reset");
      reset = 1'b0;
      @(posedge clk_mem);
      src_en = 0;
      return;
    end
    c = 0;
    while (done_cnt == 0 && c < 5000) begin @(posedge clk_mem); c++; end
    check_val("run_done", (done_cnt > 0), 1'b1);
    repeat (4) @(posedge clk_mem);
`ifdef SEQ_PERF_COUNTER_EN
    exp_cc = 16'(lat);
`else
    exp_cc = 16'd0;
`endif
    check_val("rows_in", in_sent, 2 * NR);
    check_val("we_a_count", we_a_cnt, NR);
    check_val("we_b_count", we_b_cnt, NR);
    check_val("rows_out", out_cnt, NR);
    check_val("done_pulses", done_cnt, 1);
    check_val("reads_outstanding_le4", (max_out <= 4), 1'b1);
    check_val("start_cycles", start_cyc, lat);
    check_val("we_c_follows_start", wec_bad, 0);
    check_val("compute_cycles", compute_cycles, exp_cc);
    check_val("idle_flags", {busy, in_ready, enable_reading_from_mem, enable_writing_to_mem}, '0);
    src_en = 0;
  endtask

  initial begin
    repeat (3) @(negedge clk_mem);
    check_all_zero("reset_state");
    reset = 1'b0;
    run_seq(1'b1, 1'b0, 100,    5, 1'b0, -1);
    run_seq(1'b0, 1'b1, 100,    3, 1'b0, -1);
    run_seq(1'b0, 1'b0,  30, 1000, 1'b0, -1);
    run_seq(1'b0, 1'b0,  60,    4, 1'b0, 10);
    run_seq(1'b0, 1'b0, 100,    7, 1'b1, -1);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
